ipsxb_seu_uart_rx_word: RTL
===========================

IPSXB_SEU_UART_RX_WORD -- requirements
Module: ipsxb_seu_uart_rx_word

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning the number of clk_en strobes per UART bit period; legal values are even and 8..64.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 40, meaning the inter-byte idle limit in bit periods; used only with RX_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  system clock; all logic in this block is clocked by clk on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; it is asynchronous and active-low.
REQ-005 SHALL have port clk_en  input  1  single-cycle baud strobe at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rxd_in  input  1  asynchronous serial line, 8N1 format, LSB first, idle high.
REQ-007 SHALL have port rx_word_data  output  32  assembled word.
REQ-008 SHALL have port rx_word_valid  output  1  rx_word_data holds an unconsumed word.
REQ-009 SHALL have port rx_word_ack  input  1  consumer acknowledge; sampled only while rx_word_valid=1.
REQ-010 SHALL have port frame_err  output  1  single-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky flag; a completed word was lost.
REQ-012 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-013 SHALL pass rxd_in through a 2-flop synchronizer; both flops reset to 1.
REQ-014 SHALL implement the bit FSM IDLE->START->DATA->STOP->IDLE; the strobe counter advances only on clk_en.
REQ-015 In IDLE, SHALL enter START on a synchronized 1->0 transition of rxd.
REQ-016 In START, SHALL sample after OVERSAMPLE/2 strobes: high -> IDLE (false start, no error); low -> DATA.
REQ-017 In DATA, SHALL sample one bit every OVERSAMPLE strobes, 8 bits, shifting LSB first; then -> STOP.
REQ-018 In STOP, SHALL sample after OVERSAMPLE strobes: high -> byte accepted; low -> frame_err pulse for 1 cycle, partial word discarded, and byte index reset to 0; -> IDLE in both cases.
REQ-019 SHALL place accepted byte n (n=0..3) into word bits [8n+7:8n]; first byte received = bits [7:0].
REQ-020 SHALL use a 2-bit byte index that wraps 3->0 when the 4th byte is accepted.
REQ-021 On the 4th accepted byte, SHALL load rx_word_data and assert rx_word_valid in the cycle after the stop-bit sampling strobe.
REQ-022 SHALL hold rx_word_data stable while rx_word_valid=1; rx_word_ack clears rx_word_valid in the next cycle.
REQ-023 If a word completes while rx_word_valid=1 and rx_word_ack=0, SHALL drop the new word, keep the old data, and set overrun.
REQ-024 If a word completes in the same cycle as rx_word_ack=1, SHALL load the new word with rx_word_valid remaining 1 and no overrun.
REQ-025 SHALL give overrun_clr priority below a same-cycle overrun set.
REQ-026 rx_word_ack while rx_word_valid=0 SHALL have no effect.

Reset
REQ-027 On rst_n low, SHALL force the FSM to IDLE and clear the counters and byte index, with rx_word_data=0, rx_word_valid=0, frame_err=0, overrun=0.
REQ-028 Reset mid-byte or mid-word SHALL discard all partial data; after release, reception SHALL resume only at the next falling edge.

Configuration
REQ-029 With macro IPSXB_UART_RX_TIMEOUT_EN defined, SHALL discard a partial word (byte index 1..3) and reset the byte index to 0 when the line stays in IDLE for TIMEOUT_BITS*OVERSAMPLE strobes; no error output is raised.
REQ-030 Without IPSXB_UART_RX_TIMEOUT_EN, SHALL retain partial words indefinitely and SHALL contain no timeout counter logic.

Verification
REQ-031 OVERSAMPLE=16: send bytes 0x78,0x56,0x34,0x12 -> rx_word_valid=1 with rx_word_data=0x12345678; ack -> valid=0 one cycle later.
REQ-032 Send byte 0xAA with stop bit low, then 0x01,0x02,0x03,0x04 -> one frame_err pulse, then word 0x04030201.
REQ-033 Send two full words without ack -> first word retained, overrun=1; pulse overrun_clr -> overrun=0.
REQ-034 Line-low glitch of 4 strobes -> FSM returns to IDLE, with no byte, no frame_err, and the byte index unchanged.
REQ-035 Assert rx_word_ack in the exact cycle a second word completes -> rx_word_valid stays 1, data updates, overrun=0.
REQ-036 With IPSXB_UART_RX_TIMEOUT_EN: send 0x11,0x22, idle for 41 bit times, then send 0xA0,0xB0,0xC0,0xD0 -> word 0xD0C0B0A0.

Source files
------------

// File: rtl/ipsxb_seu_uart_rx_word.sv
// rtl/ipsxb_seu_uart_rx_word.sv - 8N1 UART receiver packing four bytes into a 32-bit word (optional IPSXB_UART_RX_TIMEOUT_EN)
module ipsxb_seu_uart_rx_word #(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        rxd_in,
  output logic [31:0] rx_word_data,
  output logic        rx_word_valid,
  input  logic        rx_word_ack,
  output logic        frame_err,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || OVERSAMPLE > 64 || TIMEOUT_BITS < 1) begin : g_bad_param
    $error("ipsxb_seu_uart_rx_word: illegal OVERSAMPLE or TIMEOUT_BITS");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nxt;
  logic          rxd_s1, rxd_s2, rxd_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic          data_smp, stop_ok, stop_bad, word_done, timeout_hit;

  // Two-flop synchronizer plus one delay stage for falling-edge detection; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_q  <= 1'b1;
    end else begin
      rxd_s1 <= rxd_in;
      rxd_s2 <= rxd_s1;
      rxd_q  <= rxd_s2;
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Bit FSM next state and sampling strobes
  always_comb begin
    state_nxt = state;
    data_smp  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE:  if (rxd_q && !rxd_s2) state_nxt = S_START;
      S_START: if (clk_en && cnt == CNT_HALF) state_nxt = rxd_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (clk_en && cnt == CNT_FULL) begin
                 data_smp = 1'b1;
                 if (bit_idx == 3'd7) state_nxt = S_STOP;
               end
      S_STOP:  if (clk_en && cnt == CNT_FULL) begin
                 state_nxt = S_IDLE;
                 stop_ok   = rxd_s2;
                 stop_bad  = !rxd_s2;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign word_done = stop_ok && (byte_idx == 2'd3);

  // Strobe counter restarts on every state change so each phase measures from its own start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (state == S_IDLE)  cnt <= '0;
    else if (clk_en)           cnt <= (state_nxt != state || cnt == CNT_FULL) ? '0 : cnt + 1'b1;
  end

  // Data bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state == S_START)  bit_idx <= '0;
      else if (data_smp)     bit_idx <= bit_idx + 3'd1;
      if (data_smp)          shift   <= {rxd_s2, shift[7:1]};
    end
  end

`ifdef IPSXB_UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * OVERSAMPLE + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS * OVERSAMPLE - 1);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state == S_IDLE) && (byte_idx != 2'd0) && clk_en && (idle_cnt == TO_LAST);

  // Idle strobe counter, armed only while a partial word is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  idle_cnt <= '0;
    else if (state != S_IDLE || byte_idx == 2'd0 || timeout_hit) idle_cnt <= '0;
    else if (clk_en)                                             idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Byte index and partial word; a bad stop bit or idle timeout throws the partial word away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word_buf <= '0;
    end else if (stop_bad || timeout_hit) begin
      byte_idx <= '0;
    end else if (stop_ok) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    word_buf[7:0]   <= shift;
        2'd1:    word_buf[15:8]  <= shift;
        2'd2:    word_buf[23:16] <= shift;
        default: ;
      endcase
    end
  end

  // Word handoff: a completed word loads only into a free or just-acknowledged holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_word_data  <= '0;
      rx_word_valid <= 1'b0;
    end else if (word_done && (!rx_word_valid || rx_word_ack)) begin
      rx_word_data  <= {shift, word_buf};
      rx_word_valid <= 1'b1;
    end else if (rx_word_valid && rx_word_ack) begin
      rx_word_valid <= 1'b0;
    end
  end

  // Status: frame error pulse and sticky overrun (a same-cycle set wins over clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (word_done && rx_word_valid && !rx_word_ack) overrun <= 1'b1;
      else if (overrun_clr)                           overrun <= 1'b0;
    end
  end

endmodule
